mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential shift-add WxW multiplier core among N requesters.
//  Round-robin arbitration; captures the winner's operands, runs one multiplier bit per cycle,
//  returns the 2W-bit product to the winner with a one-cycle response pulse.
//  Sits between requester blocks and the multiply datapath; sole owner of the core's load/sequencing.
// PARAMETERS
//  N      4   number of requesters (2..8)
//  W      4   operand width; product is 2*W bits
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst        in   1      synchronous, active-low reset (sampled on posedge clk)
//  req        in   N      per-requester request level
//  a_in       in   N*W    multiplicand-select operand A, requester k at [k*W +: W]
//  b_in       in   N*W    operand B, requester k at [k*W +: W]
//  gnt        out  N      one-hot owner of the core; high from capture to end of response
//  busy       out  1      state != IDLE
//  rsp_valid  out  N      one-hot, one-cycle pulse: product valid for that requester
//  rsp_id     out  $clog2(N)  index of current/last owner
//  product    out  2*W    A*B, held until next response
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; gnt=0, rsp_valid=0, busy=0, rsp_id=0, product=0,
//   accumulator=0, rr pointer=0. Reset mid-operation aborts the job silently (no rsp_valid).
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: if |req, pick first set req at or after rr pointer (wrapping N-1 -> 0); capture its
//   a/b, clear accumulator, bit index i=0, set gnt/rsp_id, go CALC. No req: stay IDLE.
//  CALC: each cycle: if a_cap[i] acc += {b_cap,<<i} (2W-bit add, never overflows); i++.
//   After bit W-1 processed -> DONE.
//  DONE: product<=acc registered so rsp_valid[owner] and product are valid in the same cycle;
//   rr pointer <= owner+1 mod N; next cycle IDLE, gnt deasserts.
//  Latency (no early-done): req sampled in IDLE at edge t -> gnt high cycle t+1 ->
//   W CALC cycles -> rsp_valid in cycle t+1+W (W=4: 5 cycles after capture edge, 6-cycle job).
//  Handshake: requester holds a/b stable only until gnt seen (operands captured at grant edge);
//   req dropped before grant = withdrawn, no response. req still high in IDLE after its
//   rsp_valid = new job; rr pointer ensures other pending requesters win first.
//  req changes during CALC/DONE are ignored until IDLE. Back-to-back jobs: one IDLE cycle gap.
//  Simultaneous reqs: exactly one winner per rr rule; losers keep waiting, no starvation
//   (max wait (N-1) jobs).
//  Boundaries: a=0 or b=0 -> product 0; a=b=2^W-1 -> (2^W-1)^2 (W=4: 225 = 8'hE1).
// CONFIGURATION
//  MULT_ARB_EARLY_DONE_EN defined: in CALC, after processing bit i, if a_cap>>(i+1)==0 go DONE
//   immediately (latency = index of A's MSB set + 1 CALC cycles; a=0 -> 1 CALC cycle).
//  Undefined: always exactly W CALC cycles, fixed latency. Products identical either way.
// STRUCTURE
//  Package mult_arb_pkg: state enum {IDLE,CALC,DONE}, default W/N localparams,
//   PROD_W=2*W, IDX_W=$clog2(N) helper.
//  Sub-module mult_shift_add_core: operand capture regs, bit index, accumulator, start/step/
//   last outputs; mult_arbiter holds FSM, rr pointer, one-hot gnt/rsp decode.
// TESTING
//  Single req[2], a=4'd3,b=4'd5 -> gnt[2] next cycle, rsp_valid[2] W+1 cycles later, product=8'd15.
//  req=4'b1111 held, distinct operands -> grants in order 0,1,2,3,0; each product correct.
//  a=b=4'hF -> product 8'hE1; a=0,b=4'h9 -> product 0 (1 CALC cycle with EARLY_DONE_EN, else 4).
//  Drive rst=0 during CALC -> next cycle all outputs 0, no rsp_valid; new req served from rr=0.
//  Change a_in/b_in of owner during CALC -> product reflects captured values only.
//  EARLY_DONE_EN on: a=4'b0010,b=4'd7 -> 2 CALC cycles, product 8'd14; off: 4 CALC cycles.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the round-robin multiplier arbiter.
// Optional build macro: MULT_ARB_EARLY_DONE_EN (see mult_shift_add_core).
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Sequential shift-add multiplier datapath, one bit of A per step.
// MULT_ARB_EARLY_DONE_EN: flag last once the remaining A bits are all zero.
module mult_shift_add_core
  import mult_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 step_i,
  input  logic [W-1:0]         a_i,
  input  logic [W-1:0]         b_i,
  output logic [prod_w(W)-1:0] acc_next_o,
  output logic                 last_o
);

  localparam int PW = prod_w(W);
  localparam int BW = idx_w(W);

  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] acc_q, addend;
  logic [BW-1:0] idx_q;
  logic          idx_last;

  always_comb begin
    addend = '0;
    if (a_q[idx_q]) begin
      addend = {{W{1'b0}}, b_q} << idx_q;
    end
    acc_next_o = acc_q + addend;
  end

  assign idx_last = (idx_q == BW'(W - 1));

`ifdef MULT_ARB_EARLY_DONE_EN
  logic [W-1:0] a_rest;
  assign a_rest = (a_q >> idx_q) >> 1;
  assign last_o = idx_last || (a_rest == '0);
`else
  assign last_o = idx_last;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      idx_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_next_o;
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among N requesters.
// Optional build macro: MULT_ARB_EARLY_DONE_EN (variable-latency CALC).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       a_in,
  input  logic [N*W-1:0]       b_in,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [N-1:0]         rsp_valid,
  output logic [idx_w(N)-1:0]  rsp_id,
  output logic [prod_w(W)-1:0] product
);

  localparam int PW = prod_w(W);
  localparam int IW = idx_w(N);

  state_e        state_q;
  logic [N-1:0]  gnt_q, rsp_valid_q;
  logic          busy_q;
  logic [IW-1:0] rsp_id_q, ptr_q, ptr_d, owner_d;
  logic [PW-1:0] product_q, acc_next;
  logic          found, start, step, last;
  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_arr[k] = a_in[k*W +: W];
      b_arr[k] = b_in[k*W +: W];
    end
  end

  // First asserted request at or after the rr pointer, wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] cand;
    owner_d = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found   = 1'b1;
        owner_d = cand;
      end
    end
  end

  assign ptr_d = (rsp_id_q == IW'(N - 1)) ? '0 : rsp_id_q + 1'b1;
  assign start = (state_q == IDLE) && found;
  assign step  = (state_q == CALC);

  mult_shift_add_core #(
    .W (W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .step_i     (step),
    .a_i        (a_arr[owner_d]),
    .b_i        (b_arr[owner_d]),
    .acc_next_o (acc_next),
    .last_o     (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      product_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q  <= CALC;
            gnt_q    <= onehot(owner_d);
            rsp_id_q <= owner_d;
            busy_q   <= 1'b1;
          end
        end
        CALC: begin
          if (last) begin
            state_q     <= DONE;
            product_q   <= acc_next;
            rsp_valid_q <= onehot(rsp_id_q);
          end
        end
        DONE: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          ptr_q       <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (N=4, W=4).
// Expected CALC length follows MULT_ARB_EARLY_DONE_EN when defined.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [3:0]  gnt, rsp_valid;
  logic        busy;
  logic [1:0]  rsp_id;
  logic [7:0]  product;

  int vecs = 0;
  int errs = 0;

  mult_arbiter #(.N(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [3:0] a,
                         input logic [3:0] b);
    a_in[id*4 +: 4] = a;
    b_in[id*4 +: 4] = b;
  endtask

  function automatic int calc_cycles(input logic [3:0] a);
`ifdef MULT_ARB_EARLY_DONE_EN
    int m = 0;
    for (int i = 0; i < 4; i++) if (a[i]) m = i;
    return m + 1;
`else
    return 4;
`endif
  endfunction

  // Ticks until a response pulse appears; gives up after 20 cycles.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == 4'b0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
    tick(); tick();
    vecs++; if (gnt !== 4'b0) begin errs++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (rsp_valid !== 4'b0) begin errs++; $display("FAIL reset_rsp: got %b want 0000", rsp_valid); end
    vecs++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    vecs++; if (product !== 8'd0) begin errs++; $display("FAIL reset_prod: got %0d want 0", product); end
    rst = 1'b1;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    int n;
    set_ops(2, 4'd3, 4'd5);
    req = 4'b0100;
    tick();
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", busy); end
    vecs++; if (rsp_id !== 2'd2) begin errs++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    req = 4'b0;
    wait_rsp(n);
    vecs++; if (n !== calc_cycles(4'd3)) begin errs++; $display("FAIL single_lat: got %0d want %0d", n, calc_cycles(4'd3)); end
    vecs++; if (rsp_valid !== 4'b0100) begin errs++; $display("FAIL single_rsp: got %b want 0100", rsp_valid); end
    vecs++; if (product !== 8'd15) begin errs++; $display("FAIL single_prod: got %0d want 15", product); end
    tick();
    vecs++; if (gnt !== 4'b0 || busy !== 1'b0 || rsp_valid !== 4'b0) begin
      errs++; $display("FAIL single_end: got gnt %b busy %b rsp %b want 0", gnt, busy, rsp_valid);
    end
    vecs++; if (product !== 8'd15) begin errs++; $display("FAIL single_hold: got %0d want 15", product); end
  endtask

  task automatic test_round_robin;
    logic [3:0] as [4] = '{4'd2, 4'd7, 4'd12, 4'd9};
    logic [3:0] bs [4] = '{4'd3, 4'd9, 4'd5, 4'd14};
    logic [7:0] ps [4] = '{8'd6, 8'd63, 8'd60, 8'd126};
    int order [5] = '{0, 1, 2, 3, 0};
    int n, o;
    logic [3:0] oh;
    rst = 1'b0; req = '0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_ops(k, as[k], bs[k]);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      o  = order[j];
      oh = 4'b0001 << o;
      tick();
      vecs++; if (gnt !== oh) begin errs++; $display("FAIL rr_gnt%0d: got %b want %b", j, gnt, oh); end
      wait_rsp(n);
      vecs++; if (rsp_valid !== oh) begin errs++; $display("FAIL rr_rsp%0d: got %b want %b", j, rsp_valid, oh); end
      vecs++; if (product !== ps[o]) begin errs++; $display("FAIL rr_prod%0d: got %0d want %0d", j, product, ps[o]); end
      tick();
      vecs++; if (gnt !== 4'b0) begin errs++; $display("FAIL rr_gap%0d: got %b want 0000", j, gnt); end
    end
    req = '0;
  endtask

  task automatic test_boundary;
    int         ids [3] = '{1, 3, 2};
    logic [3:0] as  [3] = '{4'hF, 4'h0, 4'b0010};
    logic [3:0] bs  [3] = '{4'hF, 4'h9, 4'd7};
    logic [7:0] ps  [3] = '{8'hE1, 8'h00, 8'd14};
    int n;
    logic [3:0] oh;
    for (int j = 0; j < 3; j++) begin
      oh = 4'b0001 << ids[j];
      set_ops(ids[j], as[j], bs[j]);
      req = oh;
      tick();
      vecs++; if (gnt !== oh) begin errs++; $display("FAIL bnd_gnt%0d: got %b want %b", j, gnt, oh); end
      req = '0;
      wait_rsp(n);
      vecs++; if (n !== calc_cycles(as[j])) begin errs++; $display("FAIL bnd_lat%0d: got %0d want %0d", j, n, calc_cycles(as[j])); end
      vecs++; if (rsp_valid !== oh) begin errs++; $display("FAIL bnd_rsp%0d: got %b want %b", j, rsp_valid, oh); end
      vecs++; if (product !== ps[j]) begin errs++; $display("FAIL bnd_prod%0d: got %h want %h", j, product, ps[j]); end
      tick();
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bnd_idle%0d: got %b want 0", j, busy); end
    end
  endtask

  task automatic test_abort;
    int n;
    logic seen;
    set_ops(1, 4'd5, 4'd5);
    req = 4'b0010;
    tick();
    vecs++; if (gnt !== 4'b0010) begin errs++; $display("FAIL abort_gnt: got %b want 0010", gnt); end
    req = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    vecs++; if (gnt !== 4'b0 || busy !== 1'b0 || rsp_valid !== 4'b0) begin
      errs++; $display("FAIL abort_ctl: got gnt %b busy %b rsp %b want 0", gnt, busy, rsp_valid);
    end
    vecs++; if (product !== 8'd0) begin errs++; $display("FAIL abort_prod: got %0d want 0", product); end
    vecs++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL abort_id: got %0d want 0", rsp_id); end
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid !== 4'b0) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_silent: got pulse 1 want 0"); end
    set_ops(1, 4'd3, 4'd4);
    set_ops(3, 4'd6, 4'd2);
    req = 4'b1010;
    tick();
    vecs++; if (gnt !== 4'b0010) begin errs++; $display("FAIL abort_rr: got %b want 0010", gnt); end
    req = '0;
    wait_rsp(n);
    vecs++; if (product !== 8'd12) begin errs++; $display("FAIL abort_next: got %0d want 12", product); end
    tick();
  endtask

  task automatic test_operand_change;
    int n;
    set_ops(0, 4'd6, 4'd7);
    req = 4'b0001;
    tick();
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL opchg_gnt: got %b want 0001", gnt); end
    req = '0;
    set_ops(0, 4'hF, 4'hF);
    tick();
    set_ops(0, 4'd1, 4'd1);
    wait_rsp(n);
    vecs++; if (rsp_valid !== 4'b0001) begin errs++; $display("FAIL opchg_rsp: got %b want 0001", rsp_valid); end
    vecs++; if (product !== 8'd42) begin errs++; $display("FAIL opchg_prod: got %0d want 42", product); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    set_ops(2, 4'd3, 4'd3);
    req = 4'b0100;
    tick();
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL b2b_gnt0: got %b want 0100", gnt); end
    wait_rsp(n);
    vecs++; if (product !== 8'd9) begin errs++; $display("FAIL b2b_prod0: got %0d want 9", product); end
    tick();
    vecs++; if (gnt !== 4'b0) begin errs++; $display("FAIL b2b_gap: got %b want 0000", gnt); end
    set_ops(0, 4'd1, 4'd8);
    req = 4'b0101;
    tick();
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL b2b_fair: got %b want 0001", gnt); end
    req = 4'b0100;
    wait_rsp(n);
    vecs++; if (rsp_valid !== 4'b0001) begin errs++; $display("FAIL b2b_rsp1: got %b want 0001", rsp_valid); end
    vecs++; if (product !== 8'd8) begin errs++; $display("FAIL b2b_prod1: got %0d want 8", product); end
    tick();
    tick();
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL b2b_gnt2: got %b want 0100", gnt); end
    req = '0;
    wait_rsp(n);
    vecs++; if (product !== 8'd9) begin errs++; $display("FAIL b2b_prod2: got %0d want 9", product); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_abort();
    test_operand_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
